// File: rtl/rvh_tlb_miss_sched.sv
// Purpose : arbitrates DTLB/ITLB miss requests onto one shared page-table walker and
//           routes the walk completion back to the requester that issued it.
// Latency : request accepted in cycle N -> mmu_req_vld_o in cycle N+1; completion is
//           routed combinationally in the response cycle, next acceptance >= 1 cycle later.
// Backpressure: one walk in flight; both req_rdy_o stay low while a walk is outstanding,
//           while flush_vld_i is held in IDLE, and while rstn is low. mmu_req_* is held
//           stable until mmu_req_rdy_i.
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   dtlb_req_*_i / dtlb_req_rdy_o   DTLB miss request (vld/rdy handshake)
//   itlb_req_*_i / itlb_req_rdy_o   ITLB miss request (vld/rdy handshake)
//   mmu_req_*_o / mmu_req_rdy_i     request to the walker; src 0=DTLB, 1=ITLB
//   mmu_resp_vld_i                  walk complete
//   dtlb_resp_vld_o, itlb_resp_vld_o  completion routed to the issuing TLB
//   flush_vld_i / flush_grant_o     flush level request / grant (only when idle)
//   busy_o                          a walk is in flight
//
// Optional feature: define RVH_TLB_SCHED_STARVE_EN to add the ITLB anti-starvation
// counter. Without it the DTLB always has strict priority.

module rvh_tlb_miss_sched #(
   parameter int unsigned VPN_WIDTH      = 27,
   parameter int unsigned TRANS_ID_WIDTH = 3,
   parameter int unsigned ASID_WIDTH     = 16,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rstn,

   input  logic                      dtlb_req_vld_i,
   input  logic [TRANS_ID_WIDTH-1:0] dtlb_req_trans_id_i,
   input  logic [ASID_WIDTH-1:0]     dtlb_req_asid_i,
   input  logic [VPN_WIDTH-1:0]      dtlb_req_vpn_i,
   input  logic [1:0]                dtlb_req_access_type_i,
   output logic                      dtlb_req_rdy_o,

   input  logic                      itlb_req_vld_i,
   input  logic [TRANS_ID_WIDTH-1:0] itlb_req_trans_id_i,
   input  logic [ASID_WIDTH-1:0]     itlb_req_asid_i,
   input  logic [VPN_WIDTH-1:0]      itlb_req_vpn_i,
   input  logic [1:0]                itlb_req_access_type_i,
   output logic                      itlb_req_rdy_o,

   output logic                      mmu_req_vld_o,
   output logic                      mmu_req_src_o,
   output logic [TRANS_ID_WIDTH-1:0] mmu_req_trans_id_o,
   output logic [ASID_WIDTH-1:0]     mmu_req_asid_o,
   output logic [VPN_WIDTH-1:0]      mmu_req_vpn_o,
   output logic [1:0]                mmu_req_access_type_o,
   input  logic                      mmu_req_rdy_i,

   input  logic                      mmu_resp_vld_i,
   output logic                      dtlb_resp_vld_o,
   output logic                      itlb_resp_vld_o,

   input  logic                      flush_vld_i,
   output logic                      flush_grant_o,
   output logic                      busy_o
);

   // The starvation threshold must be reachable by the counter.
   if (STARVE_LIMIT == 0) begin : g_bad_starve_limit
      $error("rvh_tlb_miss_sched: STARVE_LIMIT must be at least 1");
   end

   typedef struct packed {
      logic                      src;
      logic [TRANS_ID_WIDTH-1:0] trans_id;
      logic [ASID_WIDTH-1:0]     asid;
      logic [VPN_WIDTH-1:0]      vpn;
      logic [1:0]                access_type;
   } req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_nxt;
   req_t   req_q;
   req_t   dtlb_req;
   req_t   itlb_req;
   logic   grant_d;
   logic   grant_i;
   logic   starve_force;

   assign dtlb_req = {1'b0, dtlb_req_trans_id_i, dtlb_req_asid_i,
                      dtlb_req_vpn_i, dtlb_req_access_type_i};
   assign itlb_req = {1'b1, itlb_req_trans_id_i, itlb_req_asid_i,
                      itlb_req_vpn_i, itlb_req_access_type_i};

`ifdef RVH_TLB_SCHED_STARVE_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q;

   assign starve_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

   // Counts DTLB wins taken while the ITLB was also waiting. Any ITLB win, or an
   // idle cycle with no ITLB request, ends the streak.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         starve_cnt_q <= '0;
      end else if (grant_i || (state_q == IDLE && !itlb_req_vld_i)) begin
         starve_cnt_q <= '0;
      end else if (grant_d && itlb_req_vld_i && !starve_force) begin
         starve_cnt_q <= starve_cnt_q + CNT_W'(1);
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Payload and source are captured at acceptance and held for the whole walk so
   // the walker sees a stable request and the completion can be routed back.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_q <= '0;
      end else if (grant_i) begin
         req_q <= itlb_req;
      end else if (grant_d) begin
         req_q <= dtlb_req;
      end
   end

   always_comb begin
      state_nxt       = state_q;
      grant_d         = 1'b0;
      grant_i         = 1'b0;
      flush_grant_o   = 1'b0;
      mmu_req_vld_o   = 1'b0;
      dtlb_resp_vld_o = 1'b0;
      itlb_resp_vld_o = 1'b0;
      busy_o          = 1'b0;

      case (state_q)
         IDLE: begin
            // Nothing is accepted while reset is held, so no handshake is lost
            // to the reset edge.
            if (!rstn) begin
               state_nxt = IDLE;
            end else if (flush_vld_i) begin
               flush_grant_o = 1'b1;
            end else if (itlb_req_vld_i && (!dtlb_req_vld_i || starve_force)) begin
               grant_i   = 1'b1;
               state_nxt = ISSUE;
            end else if (dtlb_req_vld_i) begin
               grant_d   = 1'b1;
               state_nxt = ISSUE;
            end
         end

         ISSUE: begin
            busy_o        = 1'b1;
            mmu_req_vld_o = 1'b1;
            if (mmu_req_rdy_i) begin
               state_nxt = WAIT;
            end
         end

         WAIT: begin
            busy_o = 1'b1;
            // Returning to IDLE rather than re-arbitrating here keeps one idle
            // cycle between a completion and the next acceptance.
            if (mmu_resp_vld_i) begin
               dtlb_resp_vld_o = !req_q.src;
               itlb_resp_vld_o = req_q.src;
               state_nxt       = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign dtlb_req_rdy_o        = grant_d;
   assign itlb_req_rdy_o        = grant_i;
   assign mmu_req_src_o         = req_q.src;
   assign mmu_req_trans_id_o    = req_q.trans_id;
   assign mmu_req_asid_o        = req_q.asid;
   assign mmu_req_vpn_o         = req_q.vpn;
   assign mmu_req_access_type_o = req_q.access_type;

endmodule

// File: doc/rvh_tlb_miss_sched.md
RVH_TLB_MISS_SCHED -- requirements
Module: rvh_tlb_miss_sched

Interface
REQ-001 SHALL have parameters: VPN_WIDTH, default 27, VPN width; TRANS_ID_WIDTH, default 3, transaction id width; ASID_WIDTH, default 16, ASID width; STARVE_LIMIT, default 4, consecutive DTLB grants before ITLB is forced.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rstn in 1 reset. One clock; reset is synchronous and active-low.
REQ-003 dtlb_req_vld_i in 1, dtlb_req_trans_id_i in TRANS_ID_WIDTH, dtlb_req_asid_i in ASID_WIDTH, dtlb_req_vpn_i in VPN_WIDTH, dtlb_req_access_type_i in 2: DTLB miss request; dtlb_req_rdy_o out 1 accept.
REQ-004 itlb_req_vld_i, itlb_req_trans_id_i, itlb_req_asid_i, itlb_req_vpn_i, itlb_req_access_type_i, itlb_req_rdy_o: same widths, ITLB miss request.
REQ-005 mmu_req_vld_o out 1, mmu_req_src_o out 1 (0=DTLB, 1=ITLB), mmu_req_trans_id_o, mmu_req_asid_o, mmu_req_vpn_o, mmu_req_access_type_o out (widths as REQ-003), mmu_req_rdy_i in 1: request to the shared walker.
REQ-006 mmu_resp_vld_i in 1 walk complete; dtlb_resp_vld_o out 1, itlb_resp_vld_o out 1 routed completion.
REQ-007 flush_vld_i in 1 flush request (level); flush_grant_o out 1 flush may proceed; busy_o out 1 walk in flight.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, WAIT; exactly one walk in flight at any time.
REQ-009 IDLE: if flush_vld_i=1, SHALL assert flush_grant_o=1 combinationally, hold both req_rdy low, stay IDLE.
REQ-010 IDLE, no flush: SHALL select one valid requester, assert only its req_rdy_o, register its payload and source, go ISSUE next cycle; no valid requester -> stay IDLE, both rdy low.
REQ-011 Selection: DTLB wins when both valid, except per REQ-020.
REQ-012 ISSUE: mmu_req_vld_o=1 with registered payload held stable until mmu_req_rdy_i=1; on handshake go WAIT.
REQ-013 WAIT: on mmu_resp_vld_i=1 pulse dtlb_resp_vld_o or itlb_resp_vld_o (per registered source) same cycle, combinationally, go IDLE.
REQ-014 mmu_resp_vld_i outside WAIT SHALL be ignored; no resp_vld_o asserted.
REQ-015 Request acceptance to mmu_req_vld_o latency: 1 cycle; response to next acceptance: minimum 1 cycle (no same-cycle bypass from WAIT).
REQ-016 flush_vld_i during ISSUE/WAIT SHALL NOT abort the walk; flush_grant_o stays 0 until IDLE is reached.
REQ-017 busy_o=1 in ISSUE and WAIT, else 0.
REQ-018 flush_grant_o=0 in ISSUE and WAIT.

Reset
REQ-019 rstn=0 at a clk edge SHALL force IDLE, clear starvation counter and registered payload to 0; all outputs 0 after that edge, including mid-walk; a late mmu_resp_vld_i is then dropped per REQ-014.

Configuration
REQ-020 Macro RVH_TLB_SCHED_STARVE_EN defined: saturating counter (width clog2(STARVE_LIMIT+1)) increments on each DTLB grant while itlb_req_vld_i=1, clears on ITLB grant or when itlb_req_vld_i=0 in IDLE; at STARVE_LIMIT ITLB wins the next arbitration.
REQ-021 Macro undefined: no counter; strict DTLB priority always.

Verification
REQ-022 Single DTLB req vpn=0x1234, trans_id=2, mmu_req_rdy_i=1 -> dtlb_req_rdy_o=1 cycle 0, mmu_req_vld_o=1 cycle 1 with vpn 0x1234 src 0; resp 3 cycles later -> dtlb_resp_vld_o one-cycle pulse, itlb_resp_vld_o=0.
REQ-023 DTLB and ITLB valid together, mmu_req_rdy_i held 0 for 5 cycles -> src 0, payload stable 5 cycles, itlb_req_rdy_o=0 throughout; ITLB served after DTLB resp.
REQ-024 With RVH_TLB_SCHED_STARVE_EN, both requesters continuously valid -> grants D,D,D,D,I,D,...; without the macro -> D only.
REQ-025 flush_vld_i raised in WAIT -> flush_grant_o=0 until resp, then 1 in IDLE; pending requests get rdy=0 while flush held.
REQ-026 rstn=0 for 1 cycle in WAIT, then mmu_resp_vld_i=1 -> no resp_vld_o, busy_o=0, next request accepted normally.
